// File: rtl/mem_slave_if.sv
// Valid/ready memory bus between a single master and the mem_slave responder.
interface mem_if;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  s_ready, s_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/mem_slave.sv
// Single-port word memory behind a valid/ready slave with programmable wait states.
// Define MEM_SLAVE_RANGE_CHK_EN to return zero, drop writes and flag o_err outside the window.
module mem_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic clk,
  input  logic rst,
  mem_if.slave mem,
  output logic o_err
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q;
  logic [31:0] mem_array [DEPTH];

  logic          load;
  logic          hs;
  logic          rd_en;
  logic          wr_en;
  logic          rd_ok;
  logic          wr_ok;
  logic [31:0]   rd_addr;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    load    = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.m_valid) load = 1'b1;
      end
      WAIT: begin
        if (!mem.m_valid) begin
          state_d = IDLE;
        end else if (mem.m_addr[31:2] != addr_q[31:2]) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = RESP;
        end
      end
      RESP: begin
        if (!mem.m_valid) begin
          state_d = IDLE;
        end else if (mem.m_addr[31:2] != addr_q[31:2]) begin
          load = 1'b1;
        end else begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A restart in WAIT/RESP reloads exactly like a fresh request from IDLE.
    if (load) begin
      addr_d  = mem.m_addr;
      wdata_d = mem.m_wdata;
      wstrb_d = mem.m_wstrb;
      cnt_d   = LAT4;
      state_d = (LATENCY == 0) ? RESP : WAIT;
    end
  end

  // With LATENCY=0 RESP is entered straight from the request, so read the live address.
  assign rd_addr = load ? mem.m_addr : addr_q;
  assign rd_idx  = word_idx(rd_addr);
  assign wr_idx  = word_idx(addr_q);
  assign rd_en   = (state_d == RESP);
  assign wr_en   = hs && (wstrb_q != 4'b0000) && wr_ok && !rst;

`ifdef MEM_SLAVE_RANGE_CHK_EN
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;
  logic err_q;

  assign rd_ok = (rd_addr >= BASE_ADDR) && (33'(rd_addr) < LIMIT);
  assign wr_ok = (addr_q >= BASE_ADDR) && (33'(addr_q) < LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hs && !wr_ok) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (rd_en) rdata_q <= rd_ok ? mem_array[rd_idx] : 32'd0;
    end
  end

  // Reads only happen on entry to RESP and writes only on leaving it, so they never collide.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_array[wr_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign mem.s_ready = (state_q == RESP);
  assign mem.s_rdata = rdata_q;

endmodule

// File: doc/mem_slave.md
MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 Parameter DEPTH, default 1024: memory size in 32-bit words; power of two, at least 4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter LATENCY, default 1: wait cycles inserted before s_ready; range 0..15.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 mem  mem_if.slave  bundle: responder end of the mem_if valid/ready interface.
REQ-007 mem.m_valid  in  1: the master requests an access.
REQ-008 mem.m_addr  in  32: byte address; bits [1:0] ignored.
REQ-009 mem.m_wdata  in  32: write data.
REQ-010 mem.m_wstrb  in  4: byte write enables; 4'b0000 means read.
REQ-011 mem.s_ready  out  1: transaction completes this cycle when m_valid is also high.
REQ-012 mem.s_rdata  out  32: read data, valid whenever s_ready is 1.
REQ-013 o_err  output  1: sticky out-of-range flag (see Configuration).

Function
REQ-014 Word index SHALL be (m_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; s_ready SHALL be 1 only in RESP.
REQ-016 IDLE, m_valid=1: capture m_addr, m_wdata and m_wstrb, load cnt=LATENCY, go to WAIT (LATENCY>0) or RESP (LATENCY=0); read mem[index] into s_rdata on entry to RESP.
REQ-017 WAIT: decrement cnt each cycle; at cnt=1 go to RESP. Read latency is 1+LATENCY cycles from the first m_valid cycle to s_ready.
REQ-018 RESP with m_valid=1 is the handshake: if the captured wstrb is nonzero, write the enabled byte lanes of the captured wdata on that edge; then go to IDLE.
REQ-019 A write SHALL return the pre-write word on s_rdata during its handshake.
REQ-020 m_valid=0 in WAIT or RESP SHALL abort: go to IDLE, discard any write, leave memory unchanged.
REQ-021 m_addr differing from the captured address in WAIT or RESP SHALL restart: recapture and reload cnt exactly as in IDLE. This supports the master's flush redirect.
REQ-022 Throughput SHALL be one transaction per LATENCY+2 cycles; after a handshake the FSM always returns to IDLE.
REQ-023 s_rdata SHALL hold its last value outside RESP.
REQ-024 Only one transaction SHALL be outstanding at a time.

Reset
REQ-025 rst=1 SHALL force IDLE, cnt=0, s_ready=0, s_rdata=0 and o_err=0 on the next edge; memory contents are not reset.
REQ-026 Reset during WAIT or RESP SHALL abort the transaction with no memory write.
REQ-027 While rst=1, no memory write SHALL occur.

Configuration
REQ-028 Macro MEM_SLAVE_RANGE_CHK_EN SHALL enable address range checking.
REQ-029 With the macro defined, an address below BASE_ADDR or at/above BASE_ADDR+4*DEPTH SHALL:
  - return s_rdata=32'h0000_0000;
  - drop any write;
  - complete the handshake with normal timing;
  - set o_err at the handshake edge and hold it until rst.
REQ-030 Without the macro, the index SHALL wrap modulo DEPTH and o_err SHALL be tied to 0.

Verification
REQ-031 Bench parameters: DEPTH=1024, BASE_ADDR=0, LATENCY=2. The bench SHALL cover:
  - Read: preload mem[4]=32'hCAFE_0013; m_valid=1, m_addr=0x10 at cycle T -> s_ready=1 at T+3 with s_rdata=32'hCAFE_0013; s_ready=0 at T+4.
  - Byte write: write 0x10, wdata=32'h1122_3344, wstrb=4'b0101 -> handshake s_rdata=32'hCAFE_0013; later read 0x10 -> 32'hCA22_0044.
  - Abort: write 0x20 with wstrb=4'hF; drop m_valid in WAIT -> no s_ready; read 0x20 -> original value.
  - Restart: change m_addr from 0x10 to 0x40 at T+1 -> s_ready at T+4 with mem[16] data.
  - Reset: assert rst in RESP -> s_ready=0, s_rdata=0 next cycle; no write.
  - With MEM_SLAVE_RANGE_CHK_EN: read 0x1000 -> s_rdata=0, o_err=1 held. Without the macro: read 0x1000 -> mem[0] data.
